// File: rtl/panel_io_if.sv
// Front-panel pin bundle: raw KEY/SW/HPS inputs and conditioned outputs.
// pwm_duty exists only when LED_PWM_EN is defined.
interface panel_io_if #(
    parameter int LED_W = 10,
    parameter int BTN_W = 4
);
    logic [BTN_W-1:0] button_n_raw;
    logic [LED_W-1:0] dipsw_raw;
    logic [LED_W-1:0] hps_led;
`ifdef LED_PWM_EN
    logic [3:0]       pwm_duty;
`endif
    logic [LED_W-1:0] led_out;
    logic [BTN_W-1:0] button_clean;
    logic [BTN_W-1:0] button_event;
    logic [LED_W-1:0] dipsw_clean;
    logic [1:0]       mode;
    logic             paused;

    modport master (
`ifdef LED_PWM_EN
        output pwm_duty,
`endif
        output button_n_raw, dipsw_raw, hps_led,
        input  led_out, button_clean, button_event,
        input  dipsw_clean, mode, paused
    );

    modport slave (
`ifdef LED_PWM_EN
        input  pwm_duty,
`endif
        input  button_n_raw, dipsw_raw, hps_led,
        output led_out, button_clean, button_event,
        output dipsw_clean, mode, paused
    );
endinterface

// File: rtl/panel_io_ctrl.sv
// Front-panel controller: debounce, press events, LED source select.
// Define LED_PWM_EN to add a 4-bit PWM brightness mask on led_out.
module panel_io_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICK_CYCLES     = 12500000,
    parameter int LED_W           = 10,
    parameter int BTN_W           = 4
) (
    input logic       clk_clk,
    input logic       reset_reset_n,
    panel_io_if.slave io
);
    localparam int NW = BTN_W + LED_W;
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        M_HPS   = 2'd0,
        M_COUNT = 2'd1,
        M_SCAN  = 2'd2,
        M_SW    = 2'd3
    } mode_t;

    logic [1:0] rst_q;
    logic       rst_n;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) rst_q <= '0;
        else                rst_q <= {rst_q[0], 1'b1};
    end
    assign rst_n = rst_q[1];

    // Buttons are inverted up front so every conditioned bit is active-high.
    logic [NW-1:0]    raw_in;
    logic [NW-1:0]    sync1, sync2, clean, clean_nxt;
    logic [DW-1:0]    stab [NW];
    logic [BTN_W-1:0] btn_event;

    assign raw_in = {io.dipsw_raw, ~io.button_n_raw};

    always_comb begin
        clean_nxt = clean;
        for (int i = 0; i < NW; i++) begin
            if (sync2[i] != clean[i] && stab[i] == DEB_LAST)
                clean_nxt[i] = sync2[i];
        end
    end

    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            clean     <= '0;
            btn_event <= '0;
            for (int i = 0; i < NW; i++) stab[i] <= '0;
        end else begin
            sync1     <= raw_in;
            sync2     <= sync1;
            clean     <= clean_nxt;
            btn_event <= clean_nxt[BTN_W-1:0] & ~clean[BTN_W-1:0];
            for (int i = 0; i < NW; i++) begin
                if (sync2[i] == clean[i] || stab[i] == DEB_LAST)
                    stab[i] <= '0;
                else
                    stab[i] <= stab[i] + DW'(1);
            end
        end
    end

    mode_t            mode_q, mode_nxt;
    logic             paused_q;
    logic [TW-1:0]    presc;
    logic [LED_W-1:0] count;
    logic [LED_W-1:0] scan;
    logic             dir_up;
    logic             run;
    logic             tick;

    always_comb begin
        mode_nxt = M_HPS;
        unique case (mode_q)
            M_HPS:   mode_nxt = M_COUNT;
            M_COUNT: mode_nxt = M_SCAN;
            M_SCAN:  mode_nxt = M_SW;
            M_SW:    mode_nxt = M_HPS;
        endcase
    end

    assign run  = (mode_q == M_COUNT || mode_q == M_SCAN) && !paused_q;
    assign tick = run && (presc == TICK_LAST);

    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= M_HPS;
            paused_q <= 1'b0;
            presc    <= '0;
            count    <= '0;
            scan     <= LED_W'(1);
            dir_up   <= 1'b1;
        end else if (btn_event[0]) begin
            mode_q   <= mode_nxt;
            paused_q <= 1'b0;
            presc    <= '0;
            count    <= '0;
            scan     <= LED_W'(1);
            dir_up   <= 1'b1;
        end else begin
            if (btn_event[1]) paused_q <= !paused_q;
            if (tick) begin
                presc <= '0;
                if (mode_q == M_COUNT) begin
                    count <= count + LED_W'(1);
                end else begin
                    // Bounce at either end without repeating the end bit.
                    unique case (1'b1)
                        dir_up && scan[LED_W-1]: begin
                            scan   <= scan >> 1;
                            dir_up <= 1'b0;
                        end
                        dir_up && !scan[LED_W-1]:
                            scan <= scan << 1;
                        !dir_up && scan[0]: begin
                            scan   <= scan << 1;
                            dir_up <= 1'b1;
                        end
                        !dir_up && !scan[0]:
                            scan <= scan >> 1;
                    endcase
                end
            end else if (run) begin
                presc <= presc + TW'(1);
            end
        end
    end

    logic [LED_W-1:0] src;
    logic [LED_W-1:0] led_q;

    always_comb begin
        src = io.hps_led;
        unique case (mode_q)
            M_HPS:   src = io.hps_led;
            M_COUNT: src = count;
            M_SCAN:  src = scan;
            M_SW:    src = clean[NW-1:BTN_W];
        endcase
    end

`ifdef LED_PWM_EN
    logic [3:0] pwm_cnt;
    logic       pwm_on;

    // Duty 15 is forced fully on rather than 15/16.
    assign pwm_on = (pwm_cnt < io.pwm_duty) || (io.pwm_duty == 4'hF);

    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            led_q   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            led_q   <= src & {LED_W{pwm_on}};
        end
    end
`else
    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) led_q <= '0;
        else        led_q <= src;
    end
`endif

    assign io.led_out      = led_q;
    assign io.button_clean = clean[BTN_W-1:0];
    assign io.button_event = btn_event;
    assign io.dipsw_clean  = clean[NW-1:BTN_W];
    assign io.mode         = mode_q;
    assign io.paused       = paused_q;
endmodule
